// File: rtl/lif_pkg.sv
// Shared types, default widths and saturating helpers for the spike-domain blocks.
package lif_pkg;

  localparam int unsigned SPK_CNT_W = 8;
  localparam int unsigned SPK_WIN_W = 8;
  localparam int unsigned SPK_ISI_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } dec_state_t;

  // Increment val by inc, holding at 2^width-1 instead of wrapping (width 1..32).
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic inc,
                                          input int unsigned width);
    logic [31:0] max_val;
    max_val = 32'hFFFF_FFFF >> (32 - width);
    if (inc && (val < max_val)) begin
      sat_inc = val + 32'd1;
    end else begin
      sat_inc = val;
    end
  endfunction

endpackage

// File: rtl/spike_edge_det.sv
// Registered rising-edge detector for the spike level; history cleared while disabled.
module spike_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic spike_in,
  output logic spike_edge_c
);

  logic spk_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spk_prev <= 1'b0;
    end else begin
      spk_prev <= ena ? spike_in : 1'b0;
    end
  end

  assign spike_edge_c = spike_in & ~spk_prev;

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike train -> rate: counts rising edges over back-to-back windows, delivers each count on a
// valid/ready port and reports the most recent inter-spike interval.
module spike_rate_decoder
  import lif_pkg::*;
#(
  parameter int unsigned WIN_W = SPK_WIN_W,
  parameter int unsigned CNT_W = SPK_CNT_W,
  parameter int unsigned ISI_W = SPK_ISI_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             spike_in,
  input  logic [WIN_W-1:0] window_len,
  output logic [CNT_W-1:0] rate_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic [ISI_W-1:0] isi_out,
  output logic             isi_valid
);

  dec_state_t       state_q, state_d;
  logic [WIN_W-1:0] win_cnt, win_d;
  logic [CNT_W-1:0] spk_cnt, spk_d, spk_next;
  logic [ISI_W-1:0] isi_cnt, isi_cnt_d;
  logic             isi_seen, isi_seen_d;
  logic [CNT_W-1:0] rate_d;
  logic             valid_d, overrun_d;
  logic [ISI_W-1:0] isi_out_d;
  logic             isi_valid_d;
  logic             spk_edge;

  spike_edge_det u_edge (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .spike_in     (spike_in),
    .spike_edge_c (spk_edge)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      win_cnt   <= '0;
      spk_cnt   <= '0;
      isi_cnt   <= '0;
      isi_seen  <= 1'b0;
      rate_out  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      isi_out   <= '0;
      isi_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_cnt   <= win_d;
      spk_cnt   <= spk_d;
      isi_cnt   <= isi_cnt_d;
      isi_seen  <= isi_seen_d;
      rate_out  <= rate_d;
      out_valid <= valid_d;
      overrun   <= overrun_d;
      isi_out   <= isi_out_d;
      isi_valid <= isi_valid_d;
    end
  end

  // Next-state, window/spike counters, ISI tracking and output register inputs.
  always_comb begin
    state_d     = state_q;
    win_d       = win_cnt;
    spk_d       = spk_cnt;
    isi_cnt_d   = isi_cnt;
    isi_seen_d  = isi_seen;
    rate_d      = rate_out;
    valid_d     = out_valid;
    overrun_d   = overrun;
    isi_out_d   = isi_out;
    isi_valid_d = 1'b0;
    spk_next    = CNT_W'(sat_inc(32'(spk_cnt), spk_edge, CNT_W));

    if (out_valid && out_ready) begin
      valid_d = 1'b0;
    end
    if (!ena) begin
      overrun_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        win_d      = '0;
        spk_d      = '0;
        isi_cnt_d  = '0;
        isi_seen_d = 1'b0;
        if (ena && (window_len != '0)) begin
          state_d = COUNT;
          win_d   = WIN_W'(window_len - WIN_W'(1));
        end
      end
      COUNT: begin
        if (!ena) begin
          state_d    = IDLE;
          win_d      = '0;
          spk_d      = '0;
          isi_cnt_d  = '0;
          isi_seen_d = 1'b0;
        end else begin
          if (win_cnt == '0) begin
            // Last window cycle: publish the count and re-arm without a gap cycle.
            rate_d  = spk_next;
            valid_d = 1'b1;
            if (out_valid && !out_ready) begin
              overrun_d = 1'b1;
            end
            spk_d = '0;
            if (window_len == '0) begin
              state_d = IDLE;
              win_d   = '0;
            end else begin
              win_d = WIN_W'(window_len - WIN_W'(1));
            end
          end else begin
            win_d = WIN_W'(win_cnt - WIN_W'(1));
            spk_d = spk_next;
          end

          if (spk_edge) begin
            if (isi_seen) begin
              isi_out_d   = isi_cnt;
              isi_valid_d = 1'b1;
            end
            isi_cnt_d  = ISI_W'(1);
            isi_seen_d = 1'b1;
          end else begin
            isi_cnt_d = ISI_W'(sat_inc(32'(isi_cnt), 1'b1, ISI_W));
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
